neuron_weighted_sum: RTL and testbench

Sequential multiply-accumulate front end of the artificial neuron: it accepts N signed (input, weight) pairs over a valid/ready stream, adds a signed bias, and presents one saturated M-bit signed weighted sum to the activation stage. It is the producer end of the pre-activation bus. Its `sum` output drives the activation function's `in` port directly. Its `sum_valid`/`sum_ready` handshake paces the neuron.

---
 rtl/neuron_weighted_sum.sv | 103 ++++++++++
 tb/tb_neuron_weighted_sum.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_weighted_sum.sv
// Sequential MAC front end of a neuron: accepts N signed (x, w) pairs, adds a
// bias sampled on the first beat, and presents one saturated M-bit weighted sum.
module neuron_weighted_sum #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int M = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] w,
  input  logic [M-1:0] bias,
  output logic         sum_valid,
  input  logic         sum_ready,
  output logic [M-1:0] sum
);

  localparam int PW = 2 * W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // Wide enough that N full-scale products plus any bias can never wrap.
  localparam int A  = ((M > PW + CW) ? M : PW + CW) + 1;

  typedef enum logic {
    ST_ACC,
    ST_DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        cnt;
  logic signed [A-1:0]  acc;
  logic signed [A-1:0]  acc_base;
  logic signed [A-1:0]  acc_next;
  logic signed [PW-1:0] xs;
  logic signed [PW-1:0] ws;
  logic signed [PW-1:0] prod;
  logic [M-1:0]         sat;
  logic                 accept;
  logic                 last;
  logic                 in_range;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CW'(N - 1));

  assign xs       = PW'($signed(x));
  assign ws       = PW'($signed(w));
  assign prod     = xs * ws;
  assign acc_base = (cnt == '0) ? A'($signed(bias)) : acc;
  assign acc_next = acc_base + A'(prod);

  // The value fits in M bits exactly when every bit above the M-bit sign bit
  // equals it.
  assign in_range = (&acc_next[A-1:M-1]) | ~(|acc_next[A-1:M-1]);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sat = acc_next[M-1:0];
    if (!in_range) begin
      sat = acc_next[A-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACC:  if (accept && last) state_next = ST_DONE;
      ST_DONE: if (sum_ready)      state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      cnt       <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      sum_valid <= 1'b0;
      sum       <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == ST_ACC);
      sum_valid <= (state_next == ST_DONE);
      if (accept) begin
        acc <= acc_next;
        if (last) begin
          cnt <= '0;
          sum <= sat;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (sum_valid && sum_ready) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_weighted_sum.sv
// Directed bench for neuron_weighted_sum: default M=18 instance plus an M=12
// instance sharing the same stimulus for the saturation cases.
module tb_neuron_weighted_sum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  x;
  logic [7:0]  w;
  logic [17:0] bias;
  logic        sum_ready;
  logic        in_ready;
  logic        sum_valid;
  logic [17:0] sum;
  logic [11:0] bias12;
  logic        in_ready12;
  logic        sum_valid12;
  logic [11:0] sum12;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  assign bias12 = bias[11:0];

  neuron_weighted_sum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w(w), .bias(bias), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .sum(sum)
  );

  neuron_weighted_sum #(.N(4), .W(8), .M(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
    .x(x), .w(w), .bias(bias12), .sum_valid(sum_valid12),
    .sum_ready(sum_ready), .sum(sum12)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ncyc++;

  // in_ready and sum_valid must never be high together.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (in_ready && sum_valid) begin
        errors++;
        $display("FAIL ready_valid_exclusive t=%0t in_ready=%0b sum_valid=%0b want not both 1",
                 $time, in_ready, sum_valid);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input int xi, input int wi, input int bi);
    in_valid = v;
    x        = 8'(xi);
    w        = 8'(wi);
    bias     = 18'(bi);
    cyc();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b1 || sum_valid !== 1'b0 || sum !== 18'd0) begin
      errors++;
      $display("FAIL reset_state in_ready=%0b sum_valid=%0b sum=%0d want 1 0 0",
               in_ready, sum_valid, sum);
    end
    checks++;
    if (in_ready12 !== 1'b1 || sum_valid12 !== 1'b0 || sum12 !== 12'd0) begin
      errors++;
      $display("FAIL reset_state12 in_ready=%0b sum_valid=%0b sum=%0d want 1 0 0",
               in_ready12, sum_valid12, sum12);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    checks++;
    if (in_ready !== 1'b1 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%0b sum_valid=%0b want 1 0", in_ready, sum_valid);
    end
  endtask

  task automatic test_basic();
    int xs[4] = '{3, -2, 7, 1};
    int ws[4] = '{4, 5, -1, 1};
    sum_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, xs[i], ws[i], (i == 0) ? 10 : -77);
      if (i < 3) begin
        checks++;
        if (sum_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL basic_early beat=%0d sum_valid=%0b in_ready=%0b want 0 1",
                   i, sum_valid, in_ready);
        end
      end
    end
    checks++;
    if (sum_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 18'd6) begin
      errors++;
      $display("FAIL basic_result sum_valid=%0b in_ready=%0b sum=%0d want 1 0 6",
               sum_valid, in_ready, $signed(sum));
    end
    beat(1'b0, 0, 0, 0);
    checks++;
    if (sum_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 18'd6) begin
      errors++;
      $display("FAIL basic_after sum_valid=%0b in_ready=%0b sum=%0d want 0 1 6",
               sum_valid, in_ready, $signed(sum));
    end
  endtask

  task automatic test_backpressure();
    int xs[4] = '{3, -2, 7, 1};
    int ws[4] = '{4, 5, -1, 1};
    sum_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b1, xs[i], ws[i], (i == 0) ? 10 : 55);
    checks++;
    if (sum_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 18'd6) begin
      errors++;
      $display("FAIL bp_first sum_valid=%0b in_ready=%0b sum=%0d want 1 0 6",
               sum_valid, in_ready, $signed(sum));
    end
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 99 - i, -50 + i, 123);
      checks++;
      if (sum_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 18'd6) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d sum_valid=%0b in_ready=%0b sum=%0d want 1 0 6",
                 i, sum_valid, in_ready, $signed(sum));
      end
    end
    sum_ready = 1'b1;
    beat(1'b0, 0, 0, 0);
    checks++;
    if (sum_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release sum_valid=%0b in_ready=%0b want 0 1", sum_valid, in_ready);
    end
    // A fresh sum must take exactly four beats: bias 1 + 4*(2*3) = 25.
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 2, 3, (i == 0) ? 1 : 40);
      if (i < 3) begin
        checks++;
        if (sum_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_recount beat=%0d sum_valid=%0b want 0", i, sum_valid);
        end
      end
    end
    checks++;
    if (sum_valid !== 1'b1 || sum !== 18'd25) begin
      errors++;
      $display("FAIL bp_next_sum sum_valid=%0b sum=%0d want 1 25", sum_valid, $signed(sum));
    end
    beat(1'b0, 0, 0, 0);
  endtask

  task automatic test_gaps();
    logic pv[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    sum_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (pv[i]) beat(1'b1, 127, 127, 0);
      else       beat(1'b0, -5, 9, 300);
      if (i < 6) begin
        checks++;
        if (sum_valid !== 1'b0) begin
          errors++;
          $display("FAIL gaps_early cycle=%0d sum_valid=%0b want 0", i, sum_valid);
        end
      end
    end
    checks++;
    if (sum_valid !== 1'b1 || sum !== 18'd64516) begin
      errors++;
      $display("FAIL gaps_result sum_valid=%0b sum=%0d want 1 64516", sum_valid, $signed(sum));
    end
    beat(1'b0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    sum_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(1'b1, -128, 127, 0);
    checks++;
    if (sum_valid12 !== 1'b1 || sum12 !== 12'h800) begin
      errors++;
      $display("FAIL sat_neg12 sum_valid=%0b sum=%0d want 1 -2048", sum_valid12, $signed(sum12));
    end
    checks++;
    if (sum !== 18'(-65024)) begin
      errors++;
      $display("FAIL sat_neg18 sum=%0d want -65024", $signed(sum));
    end
    beat(1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) beat(1'b1, 127, 127, 0);
    checks++;
    if (sum_valid12 !== 1'b1 || sum12 !== 12'h7FF) begin
      errors++;
      $display("FAIL sat_pos12 sum_valid=%0b sum=%0d want 1 2047", sum_valid12, $signed(sum12));
    end
    beat(1'b0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    sum_ready = 1'b1;
    beat(1'b1, 5, 5, 100);
    beat(1'b1, 5, 5, 100);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (sum_valid !== 1'b0 || sum !== 18'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async sum_valid=%0b sum=%0d in_ready=%0b want 0 0 1",
               sum_valid, $signed(sum), in_ready);
    end
    checks++;
    if (sum12 !== 12'd0) begin
      errors++;
      $display("FAIL rstmid_async12 sum=%0d want 0", $signed(sum12));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 1, 1, (i == 0) ? -4 : 60);
      if (i < 3) begin
        checks++;
        if (sum_valid !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_early beat=%0d sum_valid=%0b want 0", i, sum_valid);
        end
      end
    end
    checks++;
    if (sum_valid !== 1'b1 || sum !== 18'd0) begin
      errors++;
      $display("FAIL rstmid_result sum_valid=%0b sum=%0d want 1 0", sum_valid, $signed(sum));
    end
    beat(1'b0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int xa[4] = '{10, -3, 2, 1};
    int wa[4] = '{10, 4, 2, -1};
    int xb[4] = '{-7, 4, -1, 0};
    int wb[4] = '{8, 4, -1, 127};
    int t1 = -1;
    int t2 = -1;
    sum_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(1'b1, xa[i], wa[i], (i == 0) ? 50 : 999);
    t1 = ncyc;
    checks++;
    if (sum_valid !== 1'b1 || sum !== 18'd141) begin
      errors++;
      $display("FAIL b2b_first sum_valid=%0b sum=%0d want 1 141", sum_valid, $signed(sum));
    end
    // Held during the DONE cycle and ignored, then accepted as the first beat.
    beat(1'b1, xb[0], wb[0], -20);
    for (int i = 0; i < 4; i++) beat(1'b1, xb[i], wb[i], (i == 0) ? -20 : 777);
    t2 = ncyc;
    checks++;
    if (sum_valid !== 1'b1 || sum !== 18'(-59)) begin
      errors++;
      $display("FAIL b2b_second sum_valid=%0b sum=%0d want 1 -59", sum_valid, $signed(sum));
    end
    checks++;
    if (t2 - t1 !== 5) begin
      errors++;
      $display("FAIL b2b_period got=%0d want 5", t2 - t1);
    end
    beat(1'b0, 0, 0, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    w         = '0;
    bias      = '0;
    sum_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
